// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer driving an external single-step shifter (IDLE/SHIFT/FIN).
// Optional macro SHIFT_SEQ_ARITH_EN enables sign-filling arithmetic right shifts.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_arith,
  input  logic [WIDTH-1:0] i_d_in,
  input  logic [CNT_W-1:0] i_shamt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_d_out,
  output logic [WIDTH-1:0] o_sh_d,
  output logic             o_sh_sli,
  output logic             o_sh_sri,
  input  logic [WIDTH-1:0] i_sh_dout,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  // Handshake: i_start is sampled only while o_busy is low; o_done pulses one
  // cycle with o_d_out valid, and o_d_out holds until the next result lands.
  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_d_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_done;
  logic [WIDTH-1:0] w_step;

`ifdef SHIFT_SEQ_ARITH_EN
  logic r_arith;
  // The shifter fills with zero; keep our own MSB for a sign-filling right shift.
  assign w_step = (r_dir && r_arith) ? {r_work[WIDTH-1], i_sh_dout[WIDTH-2:0]} : i_sh_dout;
`else
  logic w_unused_arith;
  assign w_unused_arith = i_arith;
  assign w_step         = i_sh_dout;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_d_out <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
      r_arith <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_work <= i_d_in;
            r_dir  <= i_dir;
            r_cnt  <= i_shamt;
`ifdef SHIFT_SEQ_ARITH_EN
            r_arith <= i_arith;
`endif
            if (i_shamt == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_d_out <= i_d_in;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_d_out <= w_step;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;
  assign o_d_out  = r_d_out;
  assign o_sh_d   = (r_state == SHIFT) ? r_work : '0;
  assign o_sh_sli = (r_state == SHIFT) && !r_dir;
  assign o_sh_sri = (r_state == SHIFT) && r_dir;
  assign o_state  = r_state;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of the operand, result and shifter bus.
REQ-002 Parameter CNT_W, default 5, width of SHAMT; the maximum shift is 2**CNT_W-1.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 START  input  1  request; sampled only in IDLE.
REQ-007 DIR  input  1  shift direction, sampled with START; 0 = left, 1 = right.
REQ-008 ARITH  input  1  arithmetic right shift request, sampled with START.
REQ-009 D_IN  input  WIDTH  operand, sampled with START.
REQ-010 SHAMT  input  CNT_W  shift amount, sampled with START.
REQ-011 BUSY  output  1  high while an operation is in progress.
REQ-012 DONE  output  1  one-cycle completion pulse.
REQ-013 D_OUT  output  WIDTH  result, held stable from DONE until the next accepted START.
REQ-014 SH_D  output  WIDTH  operand driven to the external single-step shifter.
REQ-015 SH_SLI  output  1  shift-left-by-one command to the shifter.
REQ-016 SH_SRI  output  1  shift-right-by-one command to the shifter.
REQ-017 SH_DOUT  input  WIDTH  combinational single-step result from the shifter.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-019 IDLE with START=1 and SHAMT!=0: latch D_IN into the working register, latch DIR, ARITH and SHAMT into the counter, and go to SHIFT.
REQ-020 IDLE with START=1 and SHAMT=0: latch D_IN and go directly to FIN, so the result equals D_IN with a 1-cycle latency.
REQ-021 In SHIFT, SH_D SHALL equal the working register; SH_SLI=~DIR and SH_SRI=DIR.
REQ-022 In every other state SH_SLI=SH_SRI=0 and SH_D=0.
REQ-023 In each SHIFT cycle, the working register SHALL load SH_DOUT and the counter SHALL decrement by 1.
REQ-024 When the counter reaches 1 in SHIFT, the next state SHALL be FIN.
REQ-025 Total latency from START to DONE SHALL be SHAMT+1 cycles (SHAMT=31 gives 32 cycles).
REQ-026 In FIN, DONE=1 for exactly one cycle, D_OUT takes the working register, and the next state SHALL be IDLE.
REQ-027 BUSY SHALL be 1 in SHIFT and FIN and 0 in IDLE.
REQ-028 START while BUSY=1 SHALL be ignored, with no queuing.
REQ-029 START in the IDLE cycle immediately after FIN SHALL be accepted (back-to-back operation).
REQ-030 Inputs other than START are don't-care except in the accepting cycle.

Reset
REQ-031 RST_N low, at any time including mid-SHIFT, SHALL immediately force state=IDLE.
REQ-032 Reset SHALL clear the counter, the working register and D_OUT to 0, and set BUSY=0, DONE=0, SH_SLI=0 and SH_SRI=0.
REQ-033 An aborted operation SHALL produce no DONE pulse.
REQ-034 After RST_N deassertion, the first START SHALL be accepted on the first rising edge.

Configuration
REQ-035 Macro SHIFT_SEQ_ARITH_EN:
- Defined: for a right shift with ARITH=1, each SHIFT cycle SHALL load {working[WIDTH-1], SH_DOUT[WIDTH-2:0]}, which sign-fills the result.
- Undefined: ARITH SHALL be ignored and all right shifts are logical, loading SH_DOUT unchanged.

Verification
REQ-036 Left shift: D_IN=0x00000001, SHAMT=4, DIR=0 -> DONE in cycle 5 after START, D_OUT=0x00000010, SH_SLI high for 4 cycles.
REQ-037 Arithmetic right shift: D_IN=0xFFFFFFFE, SHAMT=1, DIR=1, ARITH=1 -> with macro D_OUT=0xFFFFFFFF, without macro D_OUT=0x7FFFFFFF.
REQ-038 Zero and maximum shift: SHAMT=0, D_IN=0x12345678 -> DONE 1 cycle after START, D_OUT=0x12345678; SHAMT=31, D_IN=1, DIR=0 -> DONE after 32 cycles, D_OUT=0x80000000.
REQ-039 Busy and back-to-back: START re-pulsed with new data during SHIFT -> ignored, result unchanged; START in the cycle after DONE -> accepted.
REQ-040 Reset mid-operation: RST_N pulsed low during SHIFT -> BUSY=0, D_OUT=0 immediately, no DONE; the next START completes normally.
